// File: rtl/rr_packet_arbiter.sv
// rtl/rr_packet_arbiter.sv - round-robin packet arbiter with flit-count, tail and watchdog release
//
// Grants one of NPORTS requesters and holds the grant for a whole packet.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   req             per-port request
//   flit_id         per-port flit type, port i at [3i+2:3i]
//   length          per-port packet length in flits, port i at [LEN_W*i +: LEN_W]
//   fire            one flit of the granted port moves this cycle
//   grant           registered one-hot grant
//   grant_idx       binary index of the granted port, 0 when idle
//   idle            high when no port is granted
//   timeout         one-cycle pulse on the cycle the watchdog forces a release
module rr_packet_arbiter #(
  parameter int          NPORTS   = 5,
  parameter int          LEN_W    = 12,
  parameter int          MAX_HOLD = 4095,
  parameter logic [2:0]  HEADER   = 3'b001,
  parameter logic [2:0]  TAIL     = 3'b100
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NPORTS-1:0]           req,
  input  logic [3*NPORTS-1:0]         flit_id,
  input  logic [LEN_W*NPORTS-1:0]     length,
  input  logic                        fire,
  output logic [NPORTS-1:0]           grant,
  output logic [$clog2(NPORTS)-1:0]   grant_idx,
  output logic                        idle,
  output logic                        timeout
);

  localparam int IW = $clog2(NPORTS);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0]     HOLD_LIMIT = HW'(MAX_HOLD);
  localparam logic [NPORTS-1:0] ONE_PORT   = NPORTS'(1);

  typedef enum logic {S_IDLE, S_LOCK} state_t;

  state_t            state;
  logic [IW-1:0]     ptr;
  logic [LEN_W-1:0]  cnt;
  logic [HW-1:0]     hold;

  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [2:0]        win_fid;
  logic [LEN_W-1:0]  win_len;
  logic [LEN_W-1:0]  load_val;
  logic [2:0]        cur_fid;
  logic              cur_req;
  logic              one_hot;
  logic              bad_state;
  logic              wd_hit;
  logic              release_now;

  // Search downward so the smallest offset from ptr+1 is the last (winning) write.
  // On a release ptr still names the releasing port, so it naturally comes last.
  always_comb begin
    int p;
    p         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NPORTS; k >= 1; k--) begin
      p = (int'(ptr) + k) % NPORTS;
      if (req[IW'(p)]) begin
        win_found = 1'b1;
        win_idx   = IW'(p);
      end
    end
  end

  assign win_fid = flit_id[3*int'(win_idx) +: 3];
  assign win_len = length[LEN_W*int'(win_idx) +: LEN_W];

  // Non-header start means the packet ends only on a tail flit (or req drop / watchdog).
  assign load_val = (win_fid != HEADER) ? '1 :
                    (win_len == '0)     ? LEN_W'(1) : win_len;

  assign cur_fid = flit_id[3*int'(grant_idx) +: 3];
  assign cur_req = req[grant_idx];

  assign one_hot   = (grant != '0) && ((grant & (grant - ONE_PORT)) == '0);
  assign bad_state = (state == S_LOCK) ? !one_hot : (grant != '0);

  assign wd_hit      = (MAX_HOLD != 0) && (hold == HOLD_LIMIT);
  assign release_now = (state == S_LOCK) &&
                       (!cur_req || wd_hit ||
                        (fire && ((cur_fid == TAIL) || (cnt == LEN_W'(1)))));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      grant     <= '0;
      grant_idx <= '0;
      idle      <= 1'b1;
      timeout   <= 1'b0;
      ptr       <= IW'(NPORTS - 1);
      cnt       <= '0;
      hold      <= '0;
    end else begin
      timeout <= 1'b0;
      if (bad_state) begin
        state     <= S_IDLE;
        grant     <= '0;
        grant_idx <= '0;
        idle      <= 1'b1;
      end else if ((state == S_IDLE) || release_now) begin
        if (win_found) begin
          state     <= S_LOCK;
          grant     <= ONE_PORT << win_idx;
          grant_idx <= win_idx;
          idle      <= 1'b0;
          ptr       <= win_idx;
          cnt       <= load_val;
          hold      <= HW'(1);
          timeout   <= (MAX_HOLD == 1);
        end else begin
          state     <= S_IDLE;
          grant     <= '0;
          grant_idx <= '0;
          idle      <= 1'b1;
        end
      end else begin
        if (fire) cnt <= cnt - LEN_W'(1);
        hold    <= hold + HW'(1);
        // Registered so the pulse lines up with the LOCK cycle that hits the limit.
        timeout <= (MAX_HOLD != 0) && ((hold + HW'(1)) == HOLD_LIMIT);
      end
    end
  end

endmodule
